shifter: RTL and testbench
==========================

Name: shifter

Overview:
- Registered logical barrel shifter for the datapath ALU slice.
- Shifts an 8-bit operand left or right by 0-7 positions, zero-filling vacated bits.
- Captures result and status flags in an output register one clock after a valid input.
- Feeds the register-file writeback and condition flags.

Parameters:
- WIDTH, 8, operand/result width in bits.
- SHAMT_W, 3, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/direction/shift are valid this cycle.
- operand  input  WIDTH  value to shift.
- direction  input  1  1 = shift left, 0 = shift right (logical).
- shift  input  SHAMT_W  shift amount, unsigned, 0..WIDTH-1.
- result  output  WIDTH  registered shifted value.
- out_valid  output  1  result/flags were updated from a valid input on the last edge.
- carry_out  output  1  registered last bit shifted out; 0 when shift = 0.
- zero  output  1  registered flag, 1 when the registered result equals 0.

Behaviour:
- Reset is asynchronous and active-high. While reset = 1, result = 0, out_valid = 0, carry_out = 0 and zero = 0, independent of clk.
- Computation is combinational on inputs; all outputs are registered. Latency is exactly 1 clk edge; throughput is 1 operation per cycle with no stall or backpressure.
- Left shift (direction = 1): result = (operand << shift) truncated to WIDTH; low bits are zero-filled.
- Right shift (direction = 0): result = operand >> shift; high bits are zero-filled. No sign extension.
- shift = 0: result = operand, carry_out = 0, for both directions.
- carry_out when shift = s > 0:
  - left: operand[WIDTH - s]
  - right: operand[s - 1]
- zero = (next result == 0), registered together with result.
- in_valid = 1 at an edge: result, carry_out and zero load the new values; out_valid <= 1.
- in_valid = 0 at an edge: result, carry_out and zero hold their previous values; out_valid <= 0.
- Back-to-back valid inputs each produce their own result on successive cycles. There is no interaction between consecutive operations.
- Reset asserted mid-stream: outputs clear immediately. After release, the first valid input is processed normally on the next edge.
- X/unknown direction or shift with in_valid = 0 must not change held outputs.
- Implementation: log2 barrel structure (stages of 1, 2, 4), one per shift bit, with a mux per direction or bit-reversal around a single right shifter. No multiplier or "%" operators.

Test Plan:
- Right shift 1: operand 1100_0011, direction 0, shift 1, in_valid 1 -> next edge: result 0110_0001, carry_out 1, zero 0, out_valid 1.
- Left shift 2 and right shift 3, back-to-back valids:
  - cycle 1: 0011_1100, dir 1, sh 2 -> result 1111_0000, carry_out 0.
  - cycle 2: 1111_0000, dir 0, sh 3 -> result 0001_1110, carry_out 0.
- Left shift 4: 0001_0010, dir 1, sh 4 -> result 0010_0000, carry_out 1.
- Zero shifts:
  - 1010_1010, dir 0, sh 0 -> result 1010_1010, carry_out 0.
  - 0101_0101, dir 1, sh 0 -> result 0101_0101, carry_out 0.
- Zero flag and hold: 1000_0000, dir 1, sh 1 -> result 0000_0000, zero 1, carry_out 1. Then drop in_valid with random data -> outputs hold, out_valid 0.
- Async reset: assert reset between clock edges after a valid op -> result 0, flags 0, out_valid 0 immediately. Release, apply 1100_0011 >> 1 -> 0110_0001 on the next edge.

Source files
------------

// File: rtl/shifter.sv
// rtl/shifter.sv - registered logical barrel shifter with carry and zero flags
//
// Shifts an operand left or right by 0..WIDTH-1 positions, zero-filling
// vacated bits. The result, the last bit shifted out and a zero flag are
// captured in an output register on the edge where in_valid is high and
// held otherwise.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset, clears every output
//   in_valid   operand/direction/shift are valid this cycle
//   operand    value to shift
//   direction  1 = shift left, 0 = logical shift right
//   shift      unsigned shift amount
//   result     registered shifted value
//   out_valid  result/flags were loaded from a valid input on the last edge
//   carry_out  registered last bit shifted out, 0 when shift = 0
//   zero       registered flag, 1 when the registered result is 0

module shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   operand,
  input  logic               direction,
  input  logic [SHAMT_W-1:0] shift,
  output logic [WIDTH-1:0]   result,
  output logic               out_valid,
  output logic               carry_out,
  output logic               zero
);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  logic [WIDTH-1:0] pre_shift;
  logic [WIDTH-1:0] stage_val;
  logic             stage_carry;
  logic [WIDTH-1:0] shifted;

  logic [WIDTH-1:0] result_d, result_q;
  logic             out_valid_d, out_valid_q;
  logic             carry_out_d, carry_out_q;
  logic             zero_d, zero_q;

  // Left shifts reuse the right-shift barrel: reverse, shift right, reverse.
  // The bit that drops out of the right shifter at position s-1 of the
  // reversed word is operand[WIDTH-s], which is the left-shift carry.
  always_comb begin
    pre_shift   = direction ? bit_rev(operand) : operand;
    stage_val   = pre_shift;
    stage_carry = 1'b0;
    // One stage per shift bit (1, 2, 4, ...). The last active stage
    // determines the overall carry: its outgoing bit is the final bit lost.
    for (int k = 0; k < SHAMT_W; k++) begin
      if (shift[k]) begin
        stage_carry = stage_val[(1 << k) - 1];
        stage_val   = stage_val >> (1 << k);
      end
    end
    shifted = direction ? bit_rev(stage_val) : stage_val;
  end

  // in_valid gates every load so unknown direction/shift on idle cycles
  // never reaches the held outputs.
  always_comb begin
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = shifted;
      carry_out_d = stage_carry;
      zero_d      = (shifted == '0);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_shifter.sv
// tb/tb_shifter.sv - scoreboard testbench for shifter

module tb_shifter;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] operand;
  logic       direction;
  logic [2:0] shift;
  logic [7:0] result;
  logic       out_valid;
  logic       carry_out;
  logic       zero;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .operand  (operand),
    .direction(direction),
    .shift    (shift),
    .result   (result),
    .out_valid(out_valid),
    .carry_out(carry_out),
    .zero     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [7:0] op, input logic d, input logic [2:0] s);
    exp_t e;
    e.res = d ? (op << s) : (op >> s);
    if (s == 3'd0)
      e.c = 1'b0;
    else if (d)
      e.c = op[8 - int'(s)];
    else
      e.c = op[int'(s) - 1];
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  // Drive one valid operation, queue its expectation, advance past the edge.
  task automatic apply(input logic [7:0] op, input logic d, input logic [2:0] s,
                       input logic [7:0] exp_res, input logic exp_c);
    exp_t e;
    in_valid  = 1'b1;
    operand   = op;
    direction = d;
    shift     = s;
    e.res = exp_res;
    e.c   = exp_c;
    e.z   = (exp_res == 8'h00);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    operand   = 8'($urandom);
    direction = 1'bx;
    shift     = 3'bxxx;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    in_valid  = 1'b1;
    operand   = 8'hFF;
    direction = 1'b0;
    shift     = 3'd1;
    #3;
    compared++;
    if ({result, out_valid, carry_out, zero} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_initial got res=%h v=%b c=%b z=%b want all 0", result, out_valid, carry_out, zero);
    end
    @(posedge clk);
    #1;
    compared++;
    if ({result, out_valid, carry_out, zero} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_over_edge got res=%h v=%b c=%b z=%b want all 0", result, out_valid, carry_out, zero);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_idle got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_directed;
    exp_t e;
    // Table from the plan, each checked immediately after its edge; the
    // sequence runs without a gap so consecutive entries are back-to-back.
    logic [7:0] ops [6] = '{8'b1100_0011, 8'b0011_1100, 8'b1111_0000, 8'b0001_0010, 8'b1010_1010, 8'b0101_0101};
    logic       dirs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] shs [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    logic [7:0] ress[6] = '{8'b0110_0001, 8'b1111_0000, 8'b0001_1110, 8'b0010_0000, 8'b1010_1010, 8'b0101_0101};
    logic       cs  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(ops[i], dirs[i], shs[i], ress[i], cs[i]);
      e = sb.pop_front();
      last_e = e;
      compared++;
      if ({out_valid, result, carry_out, zero} !== {1'b1, e.res, e.c, e.z}) begin
        mismatched++;
        $display("FAIL directed_%0d got v=%b res=%b c=%b z=%b want v=1 res=%b c=%b z=%b",
                 i, out_valid, result, carry_out, zero, e.res, e.c, e.z);
      end
    end
  endtask

  task automatic test_zero_hold;
    exp_t e;
    apply(8'b1000_0000, 1'b1, 3'd1, 8'b0000_0000, 1'b1);
    e = sb.pop_front();
    last_e = e;
    compared++;
    if ({out_valid, result, carry_out, zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL zero_flag got v=%b res=%b c=%b z=%b want v=1 res=00000000 c=1 z=1",
               out_valid, result, carry_out, zero);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      compared++;
      if ({out_valid, result, carry_out, zero} !== {1'b0, e.res, e.c, e.z}) begin
        mismatched++;
        $display("FAIL hold_%0d got v=%b res=%b c=%b z=%b want v=0 res=%b c=%b z=%b",
                 i, out_valid, result, carry_out, zero, e.res, e.c, e.z);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    apply(8'b0111_0001, 1'b0, 3'd2, 8'b0001_1100, 1'b0);
    e = sb.pop_front();
    compared++;
    if ({out_valid, result, carry_out, zero} !== {1'b1, e.res, e.c, e.z}) begin
      mismatched++;
      $display("FAIL pre_reset_op got v=%b res=%b c=%b z=%b want v=1 res=%b c=%b z=%b",
               out_valid, result, carry_out, zero, e.res, e.c, e.z);
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({result, out_valid, carry_out, zero} !== 11'd0) begin
      mismatched++;
      $display("FAIL async_reset got res=%h v=%b c=%b z=%b want all 0", result, out_valid, carry_out, zero);
    end
    #1;
    reset = 1'b0;
    apply(8'b1100_0011, 1'b0, 3'd1, 8'b0110_0001, 1'b1);
    e = sb.pop_front();
    last_e = e;
    compared++;
    if ({out_valid, result, carry_out, zero} !== {1'b1, e.res, e.c, e.z}) begin
      mismatched++;
      $display("FAIL post_reset_op got v=%b res=%b c=%b z=%b want v=1 res=%b c=%b z=%b",
               out_valid, result, carry_out, zero, e.res, e.c, e.z);
    end
  endtask

  task automatic test_random;
    exp_t e;
    exp_t m;
    logic [7:0] op;
    logic       d;
    logic [2:0] s;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
        compared++;
        if ({out_valid, result, carry_out, zero} !== {1'b0, last_e.res, last_e.c, last_e.z}) begin
          mismatched++;
          $display("FAIL rand_hold_%0d got v=%b res=%b c=%b z=%b want v=0 res=%b c=%b z=%b",
                   i, out_valid, result, carry_out, zero, last_e.res, last_e.c, last_e.z);
        end
      end else begin
        op = 8'($urandom);
        if ($urandom_range(0, 4) == 0) op = 8'h00;
        d  = 1'($urandom);
        s  = 3'($urandom);
        m  = model(op, d, s);
        apply(op, d, s, m.res, m.c);
        e = sb.pop_front();
        last_e = e;
        compared++;
        if ({out_valid, result, carry_out, zero} !== {1'b1, e.res, e.c, e.z}) begin
          mismatched++;
          $display("FAIL rand_op_%0d op=%b d=%b s=%0d got v=%b res=%b c=%b z=%b want v=1 res=%b c=%b z=%b",
                   i, op, d, s, out_valid, result, carry_out, zero, e.res, e.c, e.z);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_hold();
    test_async_reset();
    test_random();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
